// File: rtl/jerry_life_manager.sv
// Player life/protection manager: tracks remaining lives, post-hit and spawn
// protection timing, sprite blink and the respawn/game-over sequencing.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | after reset, waiting for Start; no lives loaded
//  ALIVE    | vulnerable; any unpaused KillIn line starts a hit
//  HIT      | one-cycle bookkeeping: take a life, respawn or end the game
//  INVINC   | protection window counting down unpaused frame ticks
//  GAMEOVER | out of lives, waiting for Start
module jerry_life_manager #(
  parameter int START_LIVES   = 3,
  parameter int INVINC_FRAMES = 120,
  parameter int BLINK_BIT     = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       frame_clk,
  input  logic       Start,
  input  logic       Pause,
  input  logic [3:0] KillIn,
  output logic [2:0] Lives,
  output logic       Invincible,
  output logic       JerryVisible,
  output logic       RespawnPulse,
  output logic       GameOver
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ALIVE    = 3'd1,
    S_HIT      = 3'd2,
    S_INVINC   = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  localparam logic [2:0] LIVES_INIT  = 3'(START_LIVES);
  localparam logic [7:0] FRAMES_INIT = 8'(INVINC_FRAMES);

  state_t     state_q;
  logic [2:0] lives_q;
  logic [7:0] frame_cnt_q;
  logic       respawn_q;

  logic sync1_q;
  logic sync2_q;
  logic edge_q;
  logic frame_tick;
  logic kill;
  logic tick_run;

  // frame_clk comes from the video domain: two-flop synchroniser, then edge detect
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign frame_tick = sync2_q & ~edge_q;
  assign kill       = (|KillIn) & ~Pause;
  assign tick_run   = frame_tick & ~Pause;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      lives_q     <= 3'd0;
      frame_cnt_q <= 8'd0;
      respawn_q   <= 1'b0;
    end else begin
      respawn_q <= 1'b0;
      case (state_q)
        S_IDLE, S_GAMEOVER: begin
          if (Start) begin
            lives_q     <= LIVES_INIT;
            frame_cnt_q <= FRAMES_INIT;
            respawn_q   <= 1'b1;
            state_q     <= S_INVINC;
          end
        end
        S_ALIVE: begin
          if (kill) state_q <= S_HIT;
        end
        S_HIT: begin
          lives_q <= (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          if (lives_q <= 3'd1) begin
            state_q <= S_GAMEOVER;
          end else begin
            frame_cnt_q <= FRAMES_INIT;
            respawn_q   <= 1'b1;
            state_q     <= S_INVINC;
          end
        end
        S_INVINC: begin
          // clamp at zero so a stale count can never wrap to 255
          if (tick_run) begin
            if (frame_cnt_q <= 8'd1) begin
              frame_cnt_q <= 8'd0;
              state_q     <= S_ALIVE;
            end else begin
              frame_cnt_q <= frame_cnt_q - 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    JerryVisible = 1'b0;
    case (state_q)
      S_ALIVE, S_HIT: JerryVisible = 1'b1;
      S_INVINC:       JerryVisible = ~frame_cnt_q[BLINK_BIT];
      default:        JerryVisible = 1'b0;
    endcase
  end

  assign Invincible   = (state_q != S_ALIVE);
  assign GameOver     = (state_q == S_GAMEOVER);
  assign Lives        = lives_q;
  assign RespawnPulse = respawn_q;

endmodule

// File: tb/tb_jerry_life_manager.sv
// Directed vector bench for jerry_life_manager with INVINC_FRAMES=4, START_LIVES=3.
module tb_jerry_life_manager;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       frame_clk;
  logic       Start;
  logic       Pause;
  logic [3:0] KillIn;
  logic [2:0] Lives;
  logic       Invincible;
  logic       JerryVisible;
  logic       RespawnPulse;
  logic       GameOver;

  jerry_life_manager #(
    .START_LIVES  (3),
    .INVINC_FRAMES(4),
    .BLINK_BIT    (2)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .frame_clk   (frame_clk),
    .Start       (Start),
    .Pause       (Pause),
    .KillIn      (KillIn),
    .Lives       (Lives),
    .Invincible  (Invincible),
    .JerryVisible(JerryVisible),
    .RespawnPulse(RespawnPulse),
    .GameOver    (GameOver)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       start;
    logic       pause;
    logic [3:0] kill;
    int         frames;
    int         ncyc;
    logic [2:0] lives;
    logic       inv;
    logic       vis;
    logic       resp;
    logic       go;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic add(input logic st, input logic pa, input logic [3:0] k,
                     input int fr, input int nc, input logic [2:0] lv,
                     input logic inv, input logic vis, input logic resp, input logic go);
    vec_t v;
    v.start = st; v.pause = pa; v.kill = k; v.frames = fr; v.ncyc = nc;
    v.lives = lv; v.inv = inv; v.vis = vis; v.resp = resp; v.go = go;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    repeat (4) step();
    frame_clk = 1'b0;
    repeat (4) step();
  endtask

  task automatic check(input string name, input logic [2:0] lv, input logic inv,
                       input logic vis, input logic resp, input logic go);
    n_vec++;
    if (Lives !== lv || Invincible !== inv || JerryVisible !== vis ||
        RespawnPulse !== resp || GameOver !== go) begin
      n_fail++;
      $display("FAIL %s: got lives=%0d inv=%b vis=%b resp=%b go=%b, expected lives=%0d inv=%b vis=%b resp=%b go=%b",
               name, Lives, Invincible, JerryVisible, RespawnPulse, GameOver,
               lv, inv, vis, resp, go);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; frame_clk = 1'b0; Start = 1'b0; Pause = 1'b0; KillIn = 4'b0;

    //   st pa kill   fr nc lives inv vis resp go
    add(0, 0, 4'b0000, 0, 2, 3'd0, 1, 0, 0, 0); // idle after reset
    add(1, 0, 4'b0000, 0, 1, 3'd3, 1, 0, 1, 0); // start -> invinc, respawn
    add(0, 0, 4'b0000, 0, 1, 3'd3, 1, 0, 0, 0); // respawn one cycle only
    add(0, 0, 4'b0000, 1, 0, 3'd3, 1, 1, 0, 0); // cnt 3, blink on
    add(0, 0, 4'b0000, 2, 0, 3'd3, 1, 1, 0, 0); // cnt 1, still protected
    add(0, 0, 4'b0000, 1, 0, 3'd3, 0, 1, 0, 0); // 4th tick -> alive
    add(0, 1, 4'b0011, 0, 3, 3'd3, 0, 1, 0, 0); // kill during pause ignored
    add(1, 0, 4'b0000, 0, 2, 3'd3, 0, 1, 0, 0); // start while alive ignored
    add(0, 0, 4'b0101, 0, 1, 3'd3, 1, 1, 0, 0); // hit: invincible, lives not yet
    add(0, 0, 4'b0101, 0, 1, 3'd2, 1, 0, 1, 0); // life taken, respawn
    add(0, 0, 4'b0101, 0, 1, 3'd2, 1, 0, 0, 0); // held kill costs nothing more
    add(0, 0, 4'b0000, 0, 1, 3'd2, 1, 0, 0, 0);
    add(0, 0, 4'b0000, 2, 0, 3'd2, 1, 1, 0, 0); // cnt 2
    add(0, 1, 4'b1000, 5, 0, 3'd2, 1, 1, 0, 0); // paused: cnt held at 2
    add(0, 0, 4'b0000, 1, 0, 3'd2, 1, 1, 0, 0); // cnt 1
    add(0, 0, 4'b0000, 1, 0, 3'd2, 0, 1, 0, 0); // alive
    add(0, 0, 4'b0001, 0, 1, 3'd2, 1, 1, 0, 0); // hit
    add(0, 0, 4'b0000, 0, 1, 3'd1, 1, 0, 1, 0); // lives 1
    add(0, 0, 4'b0000, 4, 0, 3'd1, 0, 1, 0, 0); // alive
    add(0, 0, 4'b0010, 0, 1, 3'd1, 1, 1, 0, 0); // final hit
    add(0, 0, 4'b0000, 0, 1, 3'd0, 1, 0, 0, 1); // game over, no respawn
    add(0, 0, 4'b1111, 0, 2, 3'd0, 1, 0, 0, 1); // kills ignored in game over
    add(1, 0, 4'b0000, 0, 1, 3'd3, 1, 0, 1, 0); // restart
    add(0, 0, 4'b0000, 0, 1, 3'd3, 1, 0, 0, 0);

    repeat (3) @(negedge CLK);
    check("reset_held", 3'd0, 1, 0, 0, 0);
    RESET = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      Start  = vq[i].start;
      Pause  = vq[i].pause;
      KillIn = vq[i].kill;
      repeat (vq[i].frames) frame_pulse();
      repeat (vq[i].ncyc) step();
      check($sformatf("vec%0d", i), vq[i].lives, vq[i].inv, vq[i].vis, vq[i].resp, vq[i].go);
    end
    Start = 1'b0; Pause = 1'b0; KillIn = 4'b0;

    // reset in the middle of a protection window
    frame_pulse();
    check("invinc_cnt3", 3'd3, 1, 1, 0, 0);
    RESET = 1'b1;
    #1;
    check("rst_invinc_async", 3'd0, 1, 0, 0, 0);
    @(negedge CLK);
    step();
    RESET = 1'b0;
    step();
    check("rst_invinc_idle", 3'd0, 1, 0, 0, 0);

    // reset while in HIT
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("restart2", 3'd3, 1, 0, 1, 0);
    repeat (4) frame_pulse();
    check("alive2", 3'd3, 0, 1, 0, 0);
    KillIn = 4'b0100;
    step();
    KillIn = 4'b0000;
    check("hit2", 3'd3, 1, 1, 0, 0);
    RESET = 1'b1;
    #1;
    check("rst_hit_async", 3'd0, 1, 0, 0, 0);
    @(negedge CLK);
    step();
    check("rst_hit_held", 3'd0, 1, 0, 0, 0);
    RESET = 1'b0;
    step();
    step();
    check("rst_hit_idle", 3'd0, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
